// File: rtl/multicycle_ctrl_if.sv
// Data-bus handshake between the multi-cycle controller and the data memory.
// The controller issues the read/write strobes and the memory answers with busReady.
interface multicycle_ctrl_if;
    logic busReady;
    logic busWe;
    logic busRe;

    modport master (input busReady, output busWe, output busRe);
    modport slave  (output busReady, input busWe, input busRe);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE (+MEM/WB for loads
// and stores), decodes datapath controls and guards data-bus accesses with a timeout.
module multicycle_ctrl #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             instrCode,
    multicycle_ctrl_if.master       bus,
    output logic                    PCEn,
    output logic                    regFileWe,
    output logic [3:0]              aluControl,
    output logic                    aluSrcMuxSel,
    output logic [2:0]              RFWDSrcMuxSel,
    output logic                    branch,
    output logic                    jal,
    output logic                    jalr,
    output logic                    illegalInstr,
    output logic                    busError
);

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_L  = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_LU = 7'b0110111;
    localparam logic [6:0] OP_AU = 7'b0010111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JL = 7'b1100111;

    // Last wait count at which a still-stalled bus gives up.
    localparam logic [7:0] TIMEOUT_LAST = 8'(BUS_TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7b5;
    logic [7:0] wait_cnt;
    logic       illegal_q;
    logic       bus_err_q;

    function automatic logic known_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_L, OP_S, OP_B, OP_LU, OP_AU, OP_J, OP_JL: known_op = 1'b1;
            default:                                                 known_op = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            opcode    <= '0;
            func3     <= '0;
            func7b5   <= 1'b0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                opcode  <= instrCode[6:0];
                func3   <= instrCode[14:12];
                func7b5 <= instrCode[30];
            end
            // Only a stalled MEM cycle stays in MEM, so staying means one more wait.
            wait_cnt <= (state == MEM && state_next == MEM) ? wait_cnt + 8'd1 : 8'd0;
            if (state == DECODE && state_next == HALT)
                illegal_q <= 1'b1;
            if (state == MEM && state_next == HALT)
                bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        PCEn          = 1'b0;
        regFileWe     = 1'b0;
        aluControl    = 4'b0000;
        aluSrcMuxSel  = 1'b0;
        RFWDSrcMuxSel = 3'd0;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        bus.busWe     = 1'b0;
        bus.busRe     = 1'b0;

        case (state)
            FETCH: begin
                PCEn       = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                state_next = known_op(instrCode[6:0]) ? EXECUTE : HALT;
            end
            EXECUTE: begin
                state_next = FETCH;
                case (opcode)
                    OP_R: begin
                        aluControl = {func7b5, func3};
                        regFileWe  = 1'b1;
                    end
                    OP_I: begin
                        // Only the shift-right pair uses bit 30 as a selector; elsewhere it is immediate.
                        aluSrcMuxSel = 1'b1;
                        aluControl   = (func3 == 3'b101) ? {func7b5, func3} : {1'b0, func3};
                        regFileWe    = 1'b1;
                    end
                    OP_L, OP_S: begin
                        aluSrcMuxSel = 1'b1;
                        state_next   = MEM;
                    end
                    OP_B: begin
                        aluControl = {1'b0, func3};
                        branch     = 1'b1;
                    end
                    OP_LU: begin
                        regFileWe     = 1'b1;
                        RFWDSrcMuxSel = 3'd2;
                    end
                    OP_AU: begin
                        regFileWe     = 1'b1;
                        RFWDSrcMuxSel = 3'd3;
                    end
                    OP_J: begin
                        jal           = 1'b1;
                        regFileWe     = 1'b1;
                        RFWDSrcMuxSel = 3'd4;
                    end
                    OP_JL: begin
                        jal           = 1'b1;
                        jalr          = 1'b1;
                        aluSrcMuxSel  = 1'b1;
                        regFileWe     = 1'b1;
                        RFWDSrcMuxSel = 3'd4;
                    end
                    default: state_next = FETCH;
                endcase
            end
            MEM: begin
                bus.busWe = (opcode == OP_S);
                bus.busRe = (opcode != OP_S);
                if (bus.busReady)
                    state_next = (opcode == OP_S) ? FETCH : WB;
                else if (wait_cnt == TIMEOUT_LAST)
                    state_next = HALT;
                else
                    state_next = MEM;
            end
            WB: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'd1;
                state_next    = FETCH;
            end
            HALT: begin
                state_next = HALT;
            end
            default: state_next = FETCH;
        endcase
    end

    assign illegalInstr = illegal_q;
    assign busError     = bus_err_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I datapath.
- Sequences each instruction through FETCH, DECODE, EXECUTE and, for loads and stores only, MEM and WB.
- Drives the datapath's PC enable, register-file write, ALU, mux-select and branch/jump controls.
- Also drives the data-bus write/read strobes and handles bus wait-states with a timeout.

Parameters:
- BUS_TIMEOUT, 16: max cycles spent in MEM waiting for busReady before halting with busError; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instrCode  in  32  instruction from instruction memory (valid from DECODE on)
- busReady  in  1  data bus completes the current access this cycle
- PCEn  out  1  PC register load enable
- regFileWe  out  1  register-file write enable
- aluControl  out  4  ALU operation
- aluSrcMuxSel  out  1  0 = rs2, 1 = immediate
- RFWDSrcMuxSel  out  3  writeback select: 0 alu, 1 memory, 2 imm, 3 PC+imm, 4 PC+4
- branch  out  1  conditional branch qualifier
- jal  out  1  unconditional PC+imm select
- jalr  out  1  rs1 as PC-adder base
- busWe  out  1  data-bus write strobe
- busRe  out  1  data-bus read strobe
- illegalInstr  out  1  sticky: unsupported opcode seen
- busError  out  1  sticky: bus timeout

Behaviour:
- Clock and reset: one clock clk. reset is synchronous, active-high, sampled on posedge clk.
- Reset state: FSM = FETCH; wait counter = 0; latched instruction fields = 0; illegalInstr = 0; busError = 0. All outputs are Moore/decoded, so after reset PCEn = 1 (FETCH) and every other output = 0.
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH:
  - PCEn = 1: PC loads the next-PC register, which was latched in the previous EXECUTE and is 0 after reset.
  - Always goes to DECODE.
- DECODE:
  - Latch opcode[6:0], func3[14:12] and func7b5[30] from instrCode.
  - Datapath decode registers capture rs1, rs2 and imm this cycle.
  - Known opcode -> EXECUTE. Unknown opcode -> HALT and set illegalInstr.
- EXECUTE: controls decoded from the latched fields.
  - R (0110011): aluSrc = 0, aluControl = {func7b5, func3}, regFileWe = 1, RFWD = 0.
  - I (0010011): aluSrc = 1. aluControl = {func7b5, func3} when func3 = 101, else {0, func3}. regFileWe = 1, RFWD = 0.
  - L (0000011): aluSrc = 1, aluControl = 0000 (ADD) -> MEM.
  - S (0100011): aluSrc = 1, aluControl = 0000 (ADD) -> MEM.
  - B (1100011): aluSrc = 0, aluControl = {0, func3}, branch = 1, regFileWe = 0.
  - LU (0110111): regFileWe = 1, RFWD = 2.
  - AU (0010111): regFileWe = 1, RFWD = 3.
  - J (1101111): jal = 1, regFileWe = 1, RFWD = 4.
  - JL (1100111): jal = 1, jalr = 1, aluSrc = 1, regFileWe = 1, RFWD = 4.
  - All non-L/S opcodes return to FETCH.
- ALU encoding: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- MEM:
  - Load: busRe = 1. Store: busWe = 1.
  - Strobes stay asserted every cycle until busReady = 1.
  - busReady = 1 -> load goes to WB, store goes to FETCH.
  - Wait counter increments on each MEM cycle with busReady = 0 and clears on MEM exit.
  - Counter reaching BUS_TIMEOUT with busReady still 0 -> HALT, set busError, drop strobes.
  - busReady outside MEM is ignored.
- WB (load only): regFileWe = 1, RFWD = 1 (memory register), -> FETCH.
- HALT: every output 0, including PCEn. Exit only via reset.
- Output defaults: any output not listed for a state is 0. aluControl defaults to 0000. RFWDSrcMuxSel defaults to 0.
- Reset mid-operation: the synchronous reset wins over every transition. It clears the strobes and sticky flags on the next edge, even inside MEM with busReady = 1.
- Writes to x0 are issued normally; the register file masks them.
- Latency in cycles: R/I/B/LU/AU/J/JL = 3; store = 4 + waits; load = 5 + waits.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) with busReady = 0:
  - state sequence FETCH, DECODE, EXECUTE, FETCH;
  - PCEn = 1 only in cycles 0 and 3;
  - regFileWe = 1 in cycle 2 with aluControl = 0000, RFWD = 0.
- SRAI x5,x5,3 (0x4032D293): aluControl = 1101, aluSrc = 1. Then SUB (0x40208233): aluControl = 1000. Then SRLI (0x0032D293): aluControl = 0101.
- LW x6,4(x1) (0x0040A303) with busReady held 0 for 3 cycles then 1:
  - busRe = 1 for 4 cycles;
  - next cycle WB with regFileWe = 1, RFWD = 1;
  - 8 cycles total.
- SW x2,0(x1) (0x0020A023) with busReady = 0 forever:
  - busWe = 1 for 16 cycles;
  - then HALT, busError = 1, all outputs 0.
  - Assert reset -> FETCH, busError = 0.
- BEQ (0x00208463): EXECUTE has branch = 1, aluControl = 0000, regFileWe = 0. JALR x1,0(x2) (0x000100E7): jal = 1, jalr = 1, RFWD = 4, regFileWe = 1.
- instrCode = 0xFFFFFFFF: DECODE -> HALT, illegalInstr = 1, PCEn stays 0 for 10 cycles. Separately, reset asserted in MEM together with busReady = 1 -> FETCH next cycle, no WB.
